// File: rtl/color_palette_out_if.sv
// CPU-side byte access handshake into the colour RAM arbiter.
interface color_palette_out_if;
  logic        i_CPU_REQ;
  logic        i_CPU_RW;
  logic [11:0] i_CPU_ADDR;
  logic [7:0]  i_CPU_DIN;
  logic [7:0]  o_CPU_DOUT;
  logic        o_CPU_ACK;

  modport master (
    output i_CPU_REQ, i_CPU_RW, i_CPU_ADDR, i_CPU_DIN,
    input  o_CPU_DOUT, o_CPU_ACK
  );
  modport slave (
    input  i_CPU_REQ, i_CPU_RW, i_CPU_ADDR, i_CPU_DIN,
    output o_CPU_DOUT, o_CPU_ACK
  );
endinterface

// File: rtl/color_palette_out.sv
// Palette readout from the two colour RAM halves, with CPU byte access
// slotted into the gaps between pixel reads.
module cpo_chan #(
  parameter bit EXPAND = 1'b1
) (
  input  logic [4:0] c,
  output logic [7:0] y
);
  assign y = EXPAND ? {c, c[4:2]} : {c, 3'b000};
endmodule

module color_palette_out #(
  parameter bit EXPAND = 1'b1
) (
  input  logic                  i_MCLK,
  input  logic                  i_RST,
  input  logic                  i_PXCEN,
  input  logic [10:0]           i_PIXIDX,
  input  logic                  i_BLANK,
  output logic [7:0]            o_R,
  output logic [7:0]            o_G,
  output logic [7:0]            o_B,
  color_palette_out_if.slave    cpu,
  output logic [10:0]           o_CR_ADDR,
  output logic [7:0]            o_CR_DIN,
  output logic                  o_CR_RD_n,
  output logic                  o_CRH_WR_n,
  output logic                  o_CRL_WR_n,
  input  logic [7:0]            i_CRH_DOUT,
  input  logic [7:0]            i_CRL_DOUT
);
  localparam int STAGES = 2;
  localparam int NCH    = 3;

  typedef enum logic [2:0] {IDLE, CPU_RD, CPU_CAP, CPU_WR, ACK, REL} state_t;
  state_t state;

  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] blk_pipe;
  assign vld_pipe[0] = i_PXCEN;
  assign blk_pipe[0] = i_BLANK;

  // Colour word bit 15 carries no colour information.
  logic unused_b15;
  assign unused_b15 = i_CRH_DOUT[7];

  logic [14:0] word;
  assign word = {i_CRH_DOUT[6:0], i_CRL_DOUT};

  logic [NCH-1:0][4:0] ch_in;
  logic [NCH-1:0][7:0] ch_out;
  assign ch_in = {word[14:10], word[9:5], word[4:0]};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    cpo_chan #(.EXPAND(EXPAND)) u_chan (.c(ch_in[g]), .y(ch_out[g]));
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      vld_pipe[STAGES:1] <= '0;
      blk_pipe[STAGES:1] <= '0;
      o_R            <= '0;
      o_G            <= '0;
      o_B            <= '0;
      cpu.o_CPU_DOUT <= '0;
      cpu.o_CPU_ACK  <= 1'b0;
      o_CR_ADDR      <= '0;
      o_CR_DIN       <= '0;
      o_CR_RD_n      <= 1'b1;
      o_CRH_WR_n     <= 1'b1;
      o_CRL_WR_n     <= 1'b1;
      state          <= IDLE;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      blk_pipe[STAGES:1] <= blk_pipe[STAGES-1:0];
      if (vld_pipe[STAGES]) begin
        o_R <= blk_pipe[STAGES] ? 8'h00 : ch_out[0];
        o_G <= blk_pipe[STAGES] ? 8'h00 : ch_out[1];
        o_B <= blk_pipe[STAGES] ? 8'h00 : ch_out[2];
      end

      cpu.o_CPU_ACK <= 1'b0;
      o_CR_RD_n     <= 1'b1;
      o_CRH_WR_n    <= 1'b1;
      o_CRL_WR_n    <= 1'b1;

      case (state)
        IDLE: if (cpu.i_CPU_REQ && !i_PXCEN) begin
          o_CR_ADDR <= cpu.i_CPU_ADDR[11:1];
          if (cpu.i_CPU_RW) begin
            o_CR_RD_n <= 1'b0;
            state     <= CPU_RD;
          end else begin
            o_CR_DIN   <= cpu.i_CPU_DIN;
            o_CRH_WR_n <= cpu.i_CPU_ADDR[0];
            o_CRL_WR_n <= !cpu.i_CPU_ADDR[0];
            state      <= CPU_WR;
          end
        end
        CPU_RD:  state <= CPU_CAP;
        // RAM data here was registered one edge ago from the CPU address,
        // so a pixel load on the previous edge cannot have disturbed it.
        CPU_CAP: begin
          cpu.o_CPU_DOUT <= cpu.i_CPU_ADDR[0] ? i_CRL_DOUT : i_CRH_DOUT;
          cpu.o_CPU_ACK  <= 1'b1;
          state          <= ACK;
        end
        CPU_WR: begin
          cpu.o_CPU_ACK <= 1'b1;
          state         <= ACK;
        end
        ACK:     state <= REL;
        REL:     if (!cpu.i_CPU_REQ) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (i_PXCEN) begin
        o_CR_ADDR  <= i_PIXIDX;
        o_CR_RD_n  <= 1'b0;
        o_CRH_WR_n <= 1'b1;
        o_CRL_WR_n <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_color_palette_out.sv
// Scoreboarded bench: colour RAM model, pixel/CPU/write-port monitors.
module tb_color_palette_out;
  logic        clk = 1'b0;
  logic        rst;
  logic        pxcen;
  logic [10:0] pixidx;
  logic        blank;
  logic [7:0]  o_R, o_G, o_B;
  logic [10:0] cr_addr;
  logic [7:0]  cr_din;
  logic        rd_n, wrh_n, wrl_n;
  logic [7:0]  crh_dout, crl_dout;

  color_palette_out_if cpu_if();

  color_palette_out #(.EXPAND(1'b1)) dut (
    .i_MCLK(clk), .i_RST(rst), .i_PXCEN(pxcen), .i_PIXIDX(pixidx), .i_BLANK(blank),
    .o_R(o_R), .o_G(o_G), .o_B(o_B), .cpu(cpu_if),
    .o_CR_ADDR(cr_addr), .o_CR_DIN(cr_din), .o_CR_RD_n(rd_n),
    .o_CRH_WR_n(wrh_n), .o_CRL_WR_n(wrl_n),
    .i_CRH_DOUT(crh_dout), .i_CRL_DOUT(crl_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_h [2048];
  logic [7:0] ram_l [2048];

  always @(posedge clk) begin
    if (rst) begin
      ram_h[11'h012] <= 8'h7C; ram_l[11'h012] <= 8'h1F;
      ram_h[11'h100] <= 8'h03; ram_l[11'h100] <= 8'hE0;
      ram_h[11'h7FF] <= 8'h2A; ram_l[11'h7FF] <= 8'h95;
    end else begin
      if (!wrh_n) ram_h[cr_addr] <= cr_din;
      if (!wrl_n) ram_l[cr_addr] <= cr_din;
      if (!rd_n) begin
        crh_dout <= ram_h[cr_addr];
        crl_dout <= ram_l[cr_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int wr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct { bit rd; logic [7:0] data; } cpu_exp_t;
  logic [23:0] pix_q [$];
  cpu_exp_t    cpu_q [$];
  logic [20:0] wr_q  [$];

  // Bench-side timing reference: RGB is due two edges after the PXCEN edge.
  logic [2:0] px_sh;
  always @(posedge clk or posedge rst)
    if (rst) px_sh <= '0;
    else     px_sh <= {px_sh[1:0], pxcen};

  always @(negedge clk) begin
    if (!rst && px_sh[2]) begin
      if (pix_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pix_unexpected: got rgb %h, expected no pixel", {o_R, o_G, o_B});
      end else chk("pix_rgb", {8'h0, o_R, o_G, o_B}, {8'h0, pix_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && cpu_if.o_CPU_ACK) begin
      ack_cnt++;
      if (cpu_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL cpu_ack_unexpected: got ack, expected none");
      end else begin
        cpu_exp_t e;
        e = cpu_q.pop_front();
        if (e.rd) chk("cpu_dout", {24'h0, cpu_if.o_CPU_DOUT}, {24'h0, e.data});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (!wrh_n || !wrl_n)) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wr_unexpected: got strobe at addr %h, expected none", cr_addr);
      end else chk("wr_port", {11'h0, wrh_n, wrl_n, cr_addr, cr_din}, {11'h0, wr_q.pop_front()});
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rgb"}, {8'h0, o_R, o_G, o_B}, 32'h0);
    chk({nm, "_port"}, {10'h0, cr_addr, cr_din, rd_n, wrh_n, wrl_n}, {10'h0, 11'h0, 8'h0, 3'b111});
    chk({nm, "_cpu"}, {23'h0, cpu_if.o_CPU_DOUT, cpu_if.o_CPU_ACK}, 32'h0);
  endtask

  task automatic pixel(input logic [10:0] idx, input logic blk, input logic [23:0] exp);
    pixidx = idx; blank = blk; pxcen = 1'b1;
    pix_q.push_back(exp);
    @(posedge clk); #1 pxcen = 1'b0; blank = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cpu_start(input logic rw, input logic [11:0] a, input logic [7:0] d,
                           input logic exp_ack, input logic [7:0] exp_rd);
    cpu_exp_t e;
    if (exp_ack) begin
      e.rd = rw; e.data = exp_rd;
      cpu_q.push_back(e);
    end
    cpu_if.i_CPU_RW = rw; cpu_if.i_CPU_ADDR = a; cpu_if.i_CPU_DIN = d;
    cpu_if.i_CPU_REQ = 1'b1;
  endtask

  // Counts negedges until ACK is seen; hold extends REQ past the ACK.
  task automatic cpu_wait(input int hold, output int t);
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!cpu_if.o_CPU_ACK && t < 50);
    if (!cpu_if.o_CPU_ACK) begin
      n_cmp++; n_err++;
      $display("FAIL cpu_ack_timeout: got no ack, expected ack within 50 cycles");
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 cpu_if.i_CPU_REQ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    int t, a0, w0;
    rst = 1'b1; pxcen = 1'b0; pixidx = '0; blank = 1'b0;
    cpu_if.i_CPU_REQ = 1'b0; cpu_if.i_CPU_RW = 1'b1;
    cpu_if.i_CPU_ADDR = '0; cpu_if.i_CPU_DIN = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    pixel(11'h012, 1'b0, 24'hFF00FF);
    pixel(11'h012, 1'b1, 24'h000000);
    pixel(11'h100, 1'b0, 24'h00FF00);
    pixel(11'h7FF, 1'b0, 24'hADA552);

    // Low-half write then read back of the same byte.
    wr_q.push_back({2'b10, 11'h012, 8'hA5});
    cpu_start(1'b0, 12'h025, 8'hA5, 1'b1, 8'h00);
    cpu_wait(0, t);
    chk("wr_latency", t, 3);
    cpu_start(1'b1, 12'h025, 8'h00, 1'b1, 8'hA5);
    cpu_wait(0, t);
    chk("rd_latency", t, 4);
    pixel(11'h012, 1'b0, 24'h2929FF);

    // CPU request on the same edge as a pixel: pixel first, CPU one edge later.
    pixidx = 11'h100; pxcen = 1'b1;
    pix_q.push_back(24'h00FF00);
    cpu_start(1'b1, 12'h024, 8'h00, 1'b1, 8'h7C);
    @(posedge clk); #1 pxcen = 1'b0;
    @(negedge clk);
    chk("share_pix_port", {20'h0, cr_addr, rd_n}, {20'h0, 11'h100, 1'b0});
    @(negedge clk);
    chk("share_cpu_port", {20'h0, cr_addr, rd_n}, {20'h0, 11'h012, 1'b0});
    cpu_wait(0, t);
    chk("share_latency", t, 2);

    // REQ held long after ACK: exactly one access.
    a0 = ack_cnt; w0 = wr_cnt;
    wr_q.push_back({2'b01, 11'h3FF, 8'h5A});
    cpu_start(1'b0, 12'h7FE, 8'h5A, 1'b1, 8'h00);
    cpu_wait(10, t);
    chk("hold_ack_count", ack_cnt - a0, 1);
    chk("hold_wr_count", wr_cnt - w0, 1);
    cpu_start(1'b1, 12'h7FE, 8'h00, 1'b1, 8'h5A);
    cpu_wait(0, t);

    // Reset while the write strobe is low.
    a0 = ack_cnt;
    wr_q.push_back({2'b10, 11'h019, 8'h11});
    cpu_start(1'b0, 12'h033, 8'h11, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("wr_low_pre_rst", {30'h0, wrh_n, wrl_n}, {30'h0, 2'b10});
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    cpu_if.i_CPU_REQ = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_ack", ack_cnt - a0, 0);
    chk("queues_drained", pix_q.size() + cpu_q.size() + wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/color_palette_out.md
# color_palette_out

Palette readout and CPU-access arbiter between the video mixer and the two 2k×8 colour RAM halves (high byte and low byte). On each pixel-clock enable it looks up the 11-bit palette index in both halves and emits registered RGB. In the gaps between pixel reads it services 68000 byte reads and writes to colour RAM through a request/acknowledge handshake.

## Interface
- `EXPAND`, default 1 — 1: 8-bit channels `{c[4:0], c[4:2]}`; 0: `{c[4:0], 3'b000}`.
- `i_MCLK`  in  1 — master clock; all logic on the rising edge.
- `i_RST`  in  1 — asynchronous, active-high reset.
- `i_PXCEN`  in  1 — pixel clock enable; one-cycle pulse, at least 4 MCLK apart.
- `i_PIXIDX`  in  11 — palette index, sampled when `i_PXCEN`=1.
- `i_BLANK`  in  1 — blanking flag, sampled when `i_PXCEN`=1.
- `o_R`, `o_G`, `o_B`  out  8 each — pixel colour.
- `i_CPU_REQ`  in  1 — CPU access request; held until acknowledged.
- `i_CPU_RW`  in  1 — 1 = read, 0 = write.
- `i_CPU_ADDR`  in  12 — byte address. `[11:1]` is the RAM address; `[0]`=0 selects the high half, `[0]`=1 selects the low half.
- `i_CPU_DIN`  in  8 — write data.
- `o_CPU_DOUT`  out  8 — read data; valid while `o_CPU_ACK`=1 and held afterwards.
- `o_CPU_ACK`  out  1 — one-cycle completion pulse.
- `o_CR_ADDR`  out  11 — shared RAM address.
- `o_CR_DIN`  out  8 — shared RAM write data.
- `o_CR_RD_n`  out  1 — shared read strobe.
- `o_CRH_WR_n`, `o_CRL_WR_n`  out  1 each — per-half write strobes.
- `i_CRH_DOUT`, `i_CRL_DOUT`  in  8 each — registered RAM read data (1-cycle latency).

## Operation
- Colour word is `{i_CRH_DOUT, i_CRL_DOUT}`:
  - bit 15 ignored;
  - R = `[4:0]`, G = `[9:5]`, B = `[14:10]`.
- All RAM port outputs are registered.
- **Pixel path:** at an edge where `i_PXCEN`=1, the port is loaded with `o_CR_ADDR`=`i_PIXIDX`, `o_CR_RD_n`=0, both WR_n=1. `i_BLANK` goes into a 2-stage delay.
- **Pixel priority:** pixel loading overrides any CPU use of the port at that edge. The FSM never schedules a CPU port cycle on an edge where `i_PXCEN`=1.
- **CPU FSM states:**
  - IDLE: if `i_CPU_REQ`=1 and `i_PXCEN`=0, go to CPU_RD (`i_CPU_RW`=1) or CPU_WR (`i_CPU_RW`=0). If `i_PXCEN`=1, stay in IDLE and retry next cycle.
  - CPU_RD: port holds `{i_CPU_ADDR[11:1]}` with RD_n=0 for one cycle. Next state CPU_CAP.
  - CPU_CAP: capture the selected half's DOUT into `o_CPU_DOUT`. Next state ACK.
  - CPU_WR: port holds the address, `o_CR_DIN`=`i_CPU_DIN`, and the selected WR_n=0 for exactly one cycle; the other WR_n stays 1. Next state ACK.
  - ACK: `o_CPU_ACK`=1 for one cycle. Next state REL.
  - REL: wait until `i_CPU_REQ`=0, then go to IDLE. This guarantees one access per request.
- Outside pixel and CPU port cycles: `o_CR_RD_n`=1, both WR_n=1, address and data hold their last value.
- **Blanking:** if the delayed blank bit is 1, `o_R`/`o_G`/`o_B` are loaded with 0 instead of palette data.

## Timing
- **Reset:**
  - `o_R`/`o_G`/`o_B`=0, `o_CPU_DOUT`=0, `o_CPU_ACK`=0;
  - `o_CR_ADDR`=0, `o_CR_DIN`=0, `o_CR_RD_n`=1, `o_CRH_WR_n`=`o_CRL_WR_n`=1;
  - FSM in IDLE, blank pipeline cleared.
- Reset mid-access abandons the access with no ACK. A write strobe already registered low is forced high asynchronously.
- **Pixel latency:** `i_PXCEN` at edge p → port loaded at p → RAM data at p+1 → RGB registered at p+2. RGB is held until the next pixel's p+2.
- **CPU read:** enters CPU_RD at edge k → RAM data at k+1 → `o_CPU_DOUT` and ACK registered at k+2. Minimum 3 cycles from request to ACK.
- **Shared RAM output:** a pixel load at k+1 does not corrupt CPU read capture, because the capture at k+2 samples RAM data registered at k+1.
- **CPU write:** WR_n is low for the cycle after edge k; ACK is high after edge k+1.
- **Worst-case ACK latency:** request arriving on a `i_PXCEN` cycle adds 1 cycle.

## Test plan
- Preload high[0x012]=0x7C, low[0x012]=0x1F; `i_PXCEN` with `i_PIXIDX`=0x012, `EXPAND`=1 → 2 edges later R=0xFF, G=0x00, B=0xFF.
- Same pixel with `i_BLANK`=1 → RGB=0 at p+2; next unblanked pixel returns palette data.
- CPU write: `i_CPU_ADDR`=0x025, data 0xA5 → `o_CRL_WR_n` low one cycle at address 0x012, `o_CRH_WR_n` stays 1, ACK pulses once. Then a read of 0x025 → `o_CPU_DOUT`=0xA5.
- CPU request asserted on the same cycle as `i_PXCEN` → pixel read first, CPU port cycle one cycle later. Both pixel RGB and CPU data are correct.
- `i_CPU_REQ` held high for 10 cycles after ACK → exactly one write strobe and one ACK; the next access starts only after REQ drops.
- `i_RST` asserted during CPU_WR → WR_n returns to 1 immediately, no ACK, all outputs at reset values.
